// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM encoding and default sizes.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } spi_state_t;

   localparam int unsigned SPI_DATA_W      = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with single-cycle rise/fall pulses
// derived from the last two synchronised samples.
module spi_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled inputs, MSB-first byte receive to rx_data/rx_valid,
// preloaded byte shifted out on miso.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_clk,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic [1:0]        state,
   output logic [3:0]        count
);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic cs_lvl_unused, cs_rise, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(reset), .d_i(spi_clk),
      .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst_n(reset), .d_i(cs),
      .level_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst_n(reset), .d_i(mosi),
      .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   spi_state_t        state_q, state_d;
   logic [3:0]        count_q, count_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
   logic              tx_pending_q, tx_pending_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [DATA_W-1:0] rx_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         rx_shift_q   <= '0;
         tx_shift_q   <= '0;
         tx_hold_q    <= '0;
         tx_pending_q <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         tx_hold_q    <= tx_hold_d;
         tx_pending_q <= tx_pending_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      tx_hold_d    = tx_hold_q;
      tx_pending_d = tx_pending_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tx_load) begin
               tx_hold_d    = tx_data;
               tx_pending_d = 1'b1;
            end
            // A load coinciding with cs_fall goes straight into this frame.
            if (cs_fall) begin
               state_d      = ST_ACTIVE;
               count_d      = '0;
               tx_shift_d   = tx_load ? tx_data : (tx_pending_q ? tx_hold_q : '0);
               tx_pending_d = 1'b0;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               state_d     = ST_IDLE;
               count_d     = '0;
               tx_shift_d  = '0;
               frame_err_d = 1'b1;
            end else if (sclk_rise) begin
               rx_shift_d = rx_next;
               count_d    = count_q + 4'd1;
               if (count_q == 4'(DATA_W - 1)) begin
                  state_d    = ST_DONE;
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
               end
            end else if (sclk_fall) begin
               tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
         end
         ST_DONE: begin
            if (cs_rise) begin
               state_d    = ST_IDLE;
               count_d    = '0;
               tx_shift_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign miso      = (state_q != ST_IDLE) & tx_shift_q[DATA_W-1];
   assign tx_ready  = (state_q == ST_IDLE);
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign state     = state_q;
   assign count     = count_q;

endmodule
